// File: rtl/countdown_timer21bit_if.sv
// countdown_timer21bit_if: command/status bundle between a controller (master)
// and the 21-bit countdown timer (slave).
interface countdown_timer21bit_if #(
  parameter int WIDTH = 21
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause, abort,
    input  out, busy, done
  );

  modport slave (
    input  load, load_val, start, pause, abort,
    output out, busy, done
  );
endinterface

// File: rtl/countdown_timer21bit.sv
// countdown_timer21bit: loadable down-counter with pause/abort and a one-cycle
// done pulse at terminal count. Optional feature macro:
//   COUNTDOWN_AUTO_RELOAD_EN - at terminal count reload from the reload register
//                              and keep running (periodic done); otherwise one-shot.
module countdown_timer21bit #(
  parameter int WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_timer21bit_if.slave tmr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;
  logic             zdone_q, zdone_d;   // zero-count start waiting to pulse done

  logic [WIDTH-1:0] count_val;
  logic [WIDTH-1:0] reload_val;
  logic             start_ok;
  logic             zero_start;
  logic             terminal;

  // A start takes the value being loaded in the same cycle, else the held count.
  assign count_val  = tmr.load ? tmr.load_val : out_q;
  assign start_ok   = (state_q == ST_IDLE) && tmr.start && !tmr.abort;
  assign zero_start = start_ok && (count_val == '0);
  assign terminal   = (state_q == ST_RUN) && !tmr.pause && !tmr.abort && (out_q == ONE);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // The reload register as it stood before this edge, so a load during RUN
  // only affects the period after the current one.
  assign reload_val = rld_q;
`else
  assign reload_val = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort wins, then start, then run/pause/terminal moves.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a missing branch would otherwise infer a latch.
    state_d = state_q;
    if (tmr.abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok && (count_val != '0)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tmr.pause) begin
            state_d = ST_PAUSE;
          end else if (terminal) begin
            state_d = (reload_val != '0) ? ST_RUN : ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (!tmr.pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: busy follows the state register directly.
  always_comb begin
    tmr.busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    tmr.out  = out_q;
    tmr.done = done_q;
  end

  // Datapath next values: count, reload register and done pulse.
  always_comb begin
    out_d   = out_q;
    rld_d   = rld_q;
    done_d  = zdone_q;
    zdone_d = zero_start;
    if (tmr.abort) begin
      // Abort clears the count and suppresses any done; rld and load are untouched.
      out_d  = '0;
      done_d = 1'b0;
    end else begin
      if (tmr.load) rld_d = tmr.load_val;
      unique case (state_q)
        ST_IDLE: begin
          if (tmr.load) out_d = tmr.load_val;
        end
        ST_RUN: begin
          if (!tmr.pause) begin
            if (out_q > ONE) begin
              out_d = out_q - ONE;
            end else if (terminal) begin
              out_d  = reload_val;
              done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
      zdone_q <= zdone_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer21bit.sv
// tb_countdown_timer21bit: directed plus randomized stimulus for the countdown
// timer, compared every cycle against a behavioural model of the timer rules.
module tb_countdown_timer21bit;

  localparam int W = 21;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  countdown_timer21bit_if #(.WIDTH(W)) bus ();

  countdown_timer21bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining count, reload value, running/paused flags,
  // and a pending done for a start with zero count.
  logic [W-1:0] m_out;
  logic [W-1:0] m_rld;
  bit           m_run;
  bit           m_paused;
  bit           m_zpend;
  bit           m_done;

  task automatic model_reset();
    m_out    = '0;
    m_rld    = '0;
    m_run    = 1'b0;
    m_paused = 1'b0;
    m_zpend  = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] rld_old;
    logic [W-1:0] cnt;
    bit           nd;
    if (bus.abort) begin
      m_out    = '0;
      m_run    = 1'b0;
      m_paused = 1'b0;
      m_zpend  = 1'b0;
      m_done   = 1'b0;
      return;
    end
    rld_old = m_rld;
    nd      = m_zpend;
    m_zpend = 1'b0;
    if (bus.load) m_rld = bus.load_val;
    if (!m_run) begin
      cnt = bus.load ? bus.load_val : m_out;
      if (bus.load) m_out = bus.load_val;
      if (bus.start) begin
        if (cnt == '0) m_zpend = 1'b1;
        else           m_run   = 1'b1;
      end
    end else if (m_paused) begin
      if (!bus.pause) m_paused = 1'b0;
    end else if (bus.pause) begin
      m_paused = 1'b1;
    end else if (m_out == W'(1)) begin
      nd = 1'b1;
      if (AUTO) begin
        m_out = rld_old;
        m_run = (rld_old != '0);
      end else begin
        m_out = '0;
        m_run = 1'b0;
      end
    end else if (m_out > W'(1)) begin
      m_out = m_out - W'(1);
    end
    m_done = nd;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.abort    = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs sampled at the edge,
  // then compare the DUT just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_out", bus.out, m_out);
    check_bit("model_busy", bus.busy, m_run);
    check_bit("model_done", bus.done, m_done);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    check("rst_out", bus.out, '0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    check("init_out", bus.out, '0);
    check_bit("init_busy", bus.busy, 1'b0);
    check_bit("init_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted mid-RUN clears everything without a clock edge.
    bus.load = 1'b1; bus.load_val = 21'h1ABCD; bus.start = 1'b1;
    step();
    clear_inputs();
    check("mid_run_out", bus.out, 21'h1ABCD);
    check_bit("mid_run_busy", bus.busy, 1'b1);
    do_reset();

    // Start with a zero count: done one edge later, never busy.
    bus.start = 1'b1;
    step();
    clear_inputs();
    check_bit("zs_busy_k", bus.busy, 1'b0);
    check_bit("zs_done_k", bus.done, 1'b0);
    step();
    check_bit("zs_done_k1", bus.done, 1'b1);
    check_bit("zs_busy_k1", bus.busy, 1'b0);
    step();
    check_bit("zs_done_k2", bus.done, 1'b0);

    // One-shot count of 5 with load and start together.
    bus.load = 1'b1; bus.load_val = W'(5); bus.start = 1'b1;
    step();
    clear_inputs();
    check("os_out0", bus.out, W'(5));
    check_bit("os_busy0", bus.busy, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      step();
      check("os_out", bus.out, W'(5 - j));
      check_bit("os_busy", bus.busy, 1'b1);
      check_bit("os_done", bus.done, 1'b0);
    end
    step();
    check_bit("os_done_term", bus.done, 1'b1);
    check("os_out_term", bus.out, AUTO ? W'(5) : W'(0));
    check_bit("os_busy_term", bus.busy, AUTO);
    step();
    check_bit("os_done_after", bus.done, 1'b0);
    bus.abort = 1'b1;
    step();
    clear_inputs();

    // Pause: count 4, pause held for two edges once out reaches 3.
    bus.load = 1'b1; bus.load_val = W'(4); bus.start = 1'b1;
    step();
    clear_inputs();
    check("pz_out_k", bus.out, W'(4));
    step();
    check("pz_out_k1", bus.out, W'(3));
    bus.pause = 1'b1;
    step();
    check("pz_hold_a", bus.out, W'(3));
    check_bit("pz_busy_a", bus.busy, 1'b1);
    step();
    check("pz_hold_b", bus.out, W'(3));
    bus.pause = 1'b0;
    step();
    check("pz_hold_c", bus.out, W'(3));
    step();
    check("pz_out_k5", bus.out, W'(2));
    step();
    check("pz_out_k6", bus.out, W'(1));
    check_bit("pz_done_k6", bus.done, 1'b0);
    step();
    check_bit("pz_done_k7", bus.done, 1'b1);
    bus.abort = 1'b1;
    step();
    clear_inputs();

    // Abort in the terminal cycle; a load alongside it is ignored.
    bus.load = 1'b1; bus.load_val = W'(2); bus.start = 1'b1;
    step();
    clear_inputs();
    step();
    check("ab_out_pre", bus.out, W'(1));
    bus.abort = 1'b1; bus.load = 1'b1; bus.load_val = W'(7);
    step();
    clear_inputs();
    check("ab_out", bus.out, '0);
    check_bit("ab_done", bus.done, 1'b0);
    check_bit("ab_busy", bus.busy, 1'b0);
    step();
    check_bit("ab_done_next", bus.done, 1'b0);
    check("ab_out_next", bus.out, '0);

    // Maximum value counts down without wrap; start while busy is ignored.
    bus.load = 1'b1; bus.load_val = 21'h1FFFFF; bus.start = 1'b1;
    step();
    clear_inputs();
    check("mx_out0", bus.out, 21'h1FFFFF);
    step();
    check("mx_out1", bus.out, 21'h1FFFFE);
    bus.start = 1'b1;
    step();
    check("mx_out2", bus.out, 21'h1FFFFD);
    check_bit("mx_busy2", bus.busy, 1'b1);
    bus.load = 1'b1; bus.load_val = W'(3);
    step();
    clear_inputs();
    check("mx_out3", bus.out, 21'h1FFFFC);
    step();
    check("mx_out4", bus.out, 21'h1FFFFB);
    bus.abort = 1'b1;
    step();
    clear_inputs();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload with period 3, then a load of 2 mid-period.
    bus.load = 1'b1; bus.load_val = W'(3); bus.start = 1'b1;
    step();
    clear_inputs();
    for (int i = 1; i <= 9; i++) begin
      step();
      check_bit("ar3_done", bus.done, (i % 3) == 0);
      check_bit("ar3_busy", bus.busy, 1'b1);
    end
    step();
    check("ar_mid_out", bus.out, W'(2));
    bus.load = 1'b1; bus.load_val = W'(2);
    step();
    clear_inputs();
    check("ar_mid_out1", bus.out, W'(1));
    step();
    check_bit("ar_mid_done", bus.done, 1'b1);
    check("ar_mid_reload", bus.out, W'(2));
    for (int i = 1; i <= 6; i++) begin
      step();
      check_bit("ar2_done", bus.done, (i % 2) == 0);
      check_bit("ar2_busy", bus.busy, 1'b1);
    end
    bus.abort = 1'b1;
    step();
    clear_inputs();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.abort    = ($urandom_range(0, 39) == 0);
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.pause    = ($urandom_range(0, 4) == 0);
      bus.load_val = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
